// File: rtl/servo_multi_ramp.sv
// servo_multi_ramp: multi-channel servo pulse generator with per-frame,
// rate-limited motion toward host-written target positions.
//
// Ports:
//   mclk        system clock
//   rst         asynchronous active-high reset
//   cmd_valid   position command valid
//   cmd_ready   command accepted on cmd_valid && cmd_ready (low while counter == 0)
//   cmd_ch      target channel; channels >= CHANNELS are accepted and dropped
//   cmd_pos     target position in cycles above MIN_CLKS (clamped to full travel)
//   busy        bit i set while pos[i] != target[i]
//   frame_tick  one-cycle pulse at each frame start
//   servo       PWM outputs, one per channel
//
// Build option: define SERVO_STAGGER_EN to offset channel i's pulse start by
// i*STAGGER_CLKS cycles. Without it all pulses rise together.
module servo_multi_ramp #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned FRAME_CLKS   = 1000000,
    parameter int unsigned MIN_CLKS     = 50000,
    parameter int unsigned MAX_CLKS     = 100000,
    parameter int unsigned STEP_CLKS    = 500,
    parameter int unsigned POS_W        = 17,
    parameter int unsigned STAGGER_CLKS = 125000
) (
    input  logic                                               mclk,
    input  logic                                               rst,
    input  logic                                               cmd_valid,
    output logic                                               cmd_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cmd_ch,
    input  logic [POS_W-1:0]                                   cmd_pos,
    output logic [CHANNELS-1:0]                                busy,
    output logic                                               frame_tick,
    output logic [CHANNELS-1:0]                                servo
);

    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CNT_W  = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam int unsigned POSX_W = POS_W + 1;
    localparam int unsigned CMP_W  = ((CNT_W > POS_W) ? CNT_W : POS_W) + 2;
    localparam int unsigned RANGE  = MAX_CLKS - MIN_CLKS;

`ifdef SERVO_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    localparam logic [POSX_W-1:0] STEP_X = POSX_W'(STEP_CLKS);
    localparam logic [POS_W-1:0]  RANGE_P = POS_W'(RANGE);

    logic [CNT_W-1:0]  counter;
    logic [POS_W-1:0]  pos        [CHANNELS];
    logic [POS_W-1:0]  target     [CHANNELS];
    logic [POS_W-1:0]  pos_nxt    [CHANNELS];
    logic [POS_W-1:0]  target_nxt [CHANNELS];
    logic [POSX_W-1:0] delta      [CHANNELS];
    logic [CMP_W-1:0]  phase      [CHANNELS];
    logic [CHANNELS-1:0] servo_nxt;
    logic [POS_W-1:0]  cmd_clamped;
    logic              accept;

    // Commands are refused only in the ramp-update cycle.
    assign cmd_ready   = (counter != '0);
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_clamped = (cmd_pos > RANGE_P) ? RANGE_P : cmd_pos;

    // Target capture and once-per-frame ramp; POS_W+1 bit math cannot wrap.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target_nxt[i] = target[i];
            pos_nxt[i]    = pos[i];
            delta[i]      = '0;
            if (accept && (cmd_ch == CH_W'(i))) begin
                target_nxt[i] = cmd_clamped;
            end
            if (counter == '0) begin
                if (target[i] > pos[i]) begin
                    delta[i] = POSX_W'(target[i]) - POSX_W'(pos[i]);
                    if (delta[i] > STEP_X) delta[i] = STEP_X;
                    pos_nxt[i] = POS_W'(POSX_W'(pos[i]) + delta[i]);
                end else if (target[i] < pos[i]) begin
                    delta[i] = POSX_W'(pos[i]) - POSX_W'(target[i]);
                    if (delta[i] > STEP_X) delta[i] = STEP_X;
                    pos_nxt[i] = POS_W'(POSX_W'(pos[i]) - delta[i]);
                end
            end
        end
    end

    // Per-channel phase (optionally staggered) and pulse compare.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam int unsigned OFF = STAGGER ? ((g * STAGGER_CLKS) % FRAME_CLKS) : 0;
        if (OFF == 0) begin : g_direct
            assign phase[g] = CMP_W'(counter);
        end else begin : g_offset
            assign phase[g] = (counter >= CNT_W'(OFF))
                            ? CMP_W'(counter) - CMP_W'(OFF)
                            : CMP_W'(counter) + CMP_W'(FRAME_CLKS - OFF);
        end
        assign servo_nxt[g] = (phase[g] < (CMP_W'(MIN_CLKS) + CMP_W'(pos[g])));
    end

    // Staggered pulses must all finish inside one frame.
    if (STAGGER && (((CHANNELS - 1) * STAGGER_CLKS + MAX_CLKS) > FRAME_CLKS)) begin : g_bad_stagger
        $error("servo_multi_ramp: (CHANNELS-1)*STAGGER_CLKS + MAX_CLKS exceeds FRAME_CLKS");
    end

    // Frame counter, registered outputs and per-channel state.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            frame_tick <= 1'b0;
            servo      <= '0;
            busy       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pos[i]    <= '0;
                target[i] <= '0;
            end
        end else begin
            counter    <= (counter == CNT_W'(FRAME_CLKS - 1)) ? '0 : counter + CNT_W'(1);
            frame_tick <= (counter == CNT_W'(FRAME_CLKS - 1));
            servo      <= servo_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                pos[i]    <= pos_nxt[i];
                target[i] <= target_nxt[i];
                busy[i]   <= (pos_nxt[i] != target_nxt[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_multi_ramp.sv
// Scoreboard bench for servo_multi_ramp: stimulus pushes the expected per-frame
// pulse widths, rise positions and busy flags; a monitor measures each frame
// and compares when frame_tick closes it.
module tb_servo_multi_ramp;

    localparam int FRAME = 1000;
`ifdef SERVO_STAGGER_EN
    localparam int STAG = 200;
`else
    localparam int STAG = 0;
`endif

    typedef struct packed {
        logic [3:0]       busy;
        logic [3:0][15:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic [2:0]  ch3 = '0;
    logic [16:0] cpos = '0;
    logic        ready_a, ready_b, tick_a, tick_b;
    logic [3:0]  busy_a, servo_a;
    logic [4:0]  busy_b, servo_b;

    int   checks = 0;
    int   errors = 0;
    int   frame_no = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    servo_multi_ramp #(
        .CHANNELS(4), .FRAME_CLKS(1000), .MIN_CLKS(100), .MAX_CLKS(200),
        .STEP_CLKS(10), .POS_W(17), .STAGGER_CLKS(200)
    ) dut (
        .mclk(clk), .rst(rst), .cmd_valid(va), .cmd_ready(ready_a),
        .cmd_ch(ch3[1:0]), .cmd_pos(cpos), .busy(busy_a),
        .frame_tick(tick_a), .servo(servo_a)
    );

    // Five channels give cmd_ch a third bit, so channel 7 is truly out of range.
    servo_multi_ramp #(
        .CHANNELS(5), .FRAME_CLKS(1000), .MIN_CLKS(100), .MAX_CLKS(200),
        .STEP_CLKS(10), .POS_W(17), .STAGGER_CLKS(200)
    ) dut_b (
        .mclk(clk), .rst(rst), .cmd_valid(vb), .cmd_ready(ready_b),
        .cmd_ch(ch3), .cmd_pos(cpos), .busy(busy_b),
        .frame_tick(tick_b), .servo(servo_b)
    );

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL frame %0d %s: got %0d expected %0d", frame_no, nm, act, req);
        end
    endfunction

    function automatic void ex(input int w0, input int w1, input int w2, input int w3,
                               input logic [3:0] b);
        exp_t e;
        e.busy = b;
        e.w[0] = 16'(w0);
        e.w[1] = 16'(w1);
        e.w[2] = 16'(w2);
        e.w[3] = 16'(w3);
        sb.push_back(e);
    endfunction

    // Monitor: accumulate one frame, compare when frame_tick starts the next.
    int cyc, nready;
    int width [4];
    int rise  [4];
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            nready = 0;
            for (int i = 0; i < 4; i++) begin width[i] = 0; rise[i] = 0; end
        end else begin
            if (tick_a) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 0, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("period", cyc, FRAME);
                    chk("ready_low_cycles", nready, 1);
                    chk("busy", int'(busy_a), int'(e.busy));
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("width_ch%0d", i), width[i], int'(e.w[i]));
                        chk($sformatf("rise_ch%0d", i), rise[i], 1 + i * STAG);
                    end
                end
                frame_no++;
                cyc = 0;
                nready = 0;
                for (int i = 0; i < 4; i++) begin width[i] = 0; rise[i] = 0; end
            end
            for (int i = 0; i < 4; i++) begin
                if (servo_a[i]) begin
                    if (width[i] == 0) rise[i] = cyc;
                    width[i]++;
                end
            end
            if (!ready_a) nready++;
            cyc++;
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < FRAME + 100);
        if (!tick_a) chk("frame_tick_timeout", 0, 1);
    endtask

    task automatic send(input bit to_b, input int ch, input int p);
        int n = 0;
        ch3  = 3'(ch);
        cpos = 17'(p);
        if (to_b) vb = 1'b1; else va = 1'b1;
        while (!(to_b ? ready_b : ready_a) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_handshake", int'(to_b ? ready_b : ready_a), 1);
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_servo", int'(servo_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_tick", int'(tick_a), 0);
        chk("reset_ready", int'(ready_a), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        ex(100, 100, 100, 100, 4'b0000); wait_tick();                       // f0
        ex(100, 100, 100, 100, 4'b0010); send(0, 1, 35); wait_tick();       // f1
        ex(100, 110, 100, 100, 4'b0010); wait_tick();
        ex(100, 120, 100, 100, 4'b0010); wait_tick();
        ex(100, 130, 100, 100, 4'b0010); wait_tick();
        ex(100, 135, 100, 100, 4'b0000); wait_tick();                       // final step of 5
        ex(100, 135, 100, 100, 4'b0100); send(0, 2, 500); wait_tick();      // clamped to 100
        for (int j = 1; j <= 9; j++) begin
            ex(100, 135, 100 + 10 * j, 100, 4'b0100); wait_tick();
        end
        ex(100, 135, 200, 100, 4'b0000); wait_tick();                       // full travel
        ex(100, 135, 200, 100, 4'b0001); send(0, 0, 80); wait_tick();
        ex(110, 135, 200, 100, 4'b0001); wait_tick();
        ex(120, 135, 200, 100, 4'b0001); wait_tick();
        ex(130, 135, 200, 100, 4'b0001); send(0, 0, 20); wait_tick();       // retarget mid-ramp
        ex(120, 135, 200, 100, 4'b0000); wait_tick();
        ex(120, 135, 200, 100, 4'b1010);
        send(0, 1, 3);
        send(0, 3, 10);
        send(1, 7, 50);                                                     // out of range on dut_b
        wait_tick();
        chk("out_of_range_busy", int'(busy_b), 0);
        ex(120, 125, 200, 110, 4'b0010); wait_tick();
        chk("out_of_range_busy_later", int'(busy_b), 0);
        ex(120, 115, 200, 110, 4'b0010); wait_tick();
        ex(120, 105, 200, 110, 4'b0010); wait_tick();
        ex(120, 103, 200, 110, 4'b0000); wait_tick();                       // short last step down

        // Reset in the middle of the pulses.
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_servo", int'(servo_a), 0);
        chk("async_reset_servo_b", int'(servo_b), 0);
        chk("async_reset_ready", int'(ready_a), 0);
        chk("async_reset_tick", int'(tick_a), 0);
        repeat (3) @(negedge clk);
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        ex(100, 100, 100, 100, 4'b0000); wait_tick();
        ex(100, 100, 100, 100, 4'b0000); wait_tick();
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
